// File: rtl/regfile_write_queue.sv
// In-order writeback queue that feeds the register file write port and exposes queued writes to forwarding.
// Optional same-cycle bypass of an empty queue: define WBQ_BYPASS_EN.
module regfile_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_reg,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      wb_enable,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  input  logic [ADDR_W-1:0]         query1,
  input  logic [ADDR_W-1:0]         query2,
  output logic                      hit1,
  output logic                      hit2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem_reg  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_bypass;
  logic              w_q_write;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_idx;
  logic              w_hit1;
  logic              w_hit2;
  logic [DATA_W-1:0] w_fwd1;
  logic [DATA_W-1:0] w_fwd2;

  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign in_ready = !reset && (r_count < CNT_W'(DEPTH));

`ifdef WBQ_BYPASS_EN
  assign w_bypass = empty && wb_enable && in_valid && in_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_write = !reset && wb_enable && !empty;
  assign w_pop     = w_q_write;
  assign w_push    = in_valid && in_ready && !w_bypass;

  // Write port: queue head has priority; bypass only happens when the queue is empty
  always_comb begin
    reg_write  = w_q_write || w_bypass;
    write_reg  = '0;
    write_data = '0;
    if (w_q_write) begin
      write_reg  = r_mem_reg[r_rd_ptr];
      write_data = r_mem_data[r_rd_ptr];
    end else if (w_bypass) begin
      write_reg  = in_reg;
      write_data = in_data;
    end
  end

  // Associative lookup, oldest to youngest so the youngest match wins
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    w_idx  = '0;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_idx = r_rd_ptr + PTR_W'(i);
        if (CNT_W'(i) < r_count) begin
          if (r_mem_reg[w_idx] == query1) begin
            w_hit1 = 1'b1;
            w_fwd1 = r_mem_data[w_idx];
          end
          if (r_mem_reg[w_idx] == query2) begin
            w_hit2 = 1'b1;
            w_fwd2 = r_mem_data[w_idx];
          end
        end
      end
    end
  end

  assign hit1      = w_hit1;
  assign hit2      = w_hit2;
  assign fwd_data1 = w_fwd1;
  assign fwd_data2 = w_fwd2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_wr_ptr]  <= in_reg;
      r_mem_data[r_wr_ptr] <= in_data;
    end
  end

endmodule
